touch_adc_reader: RTL and testbench
===================================

# touch_adc_reader

Upstream front end of the touch path. Drives an XPT2046-class resistive-touch ADC over SPI, takes bursts of X/Y conversions while the pen is down, averages them and scales them to 320×240 screen coordinates. Its outputs are a 9-bit X, an 8-bit Y and a one-cycle valid strobe, which feed the touch-processing/palette stage directly.

## Interface
- `CLK_DIV`, default 50: `clk_in` cycles per SCLK half-period. SCLK period is 2·CLK_DIV.
- `SAMPLE_PERIOD`, default 1_000_000: `clk_in` cycles from one burst start to the next.
- `AVG_LOG2`, default 2: each burst holds 2^AVG_LOG2 X/Y conversion pairs.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `penirq_n_in` input 1: ADC pen-down, active-low, asynchronous. Synchronised with 2 flops.
- `spi_miso_in` input 1: ADC data out.
- `spi_sclk_out` output 1: SPI clock, idles low.
- `spi_mosi_out` output 1: command bits.
- `spi_cs_n_out` output 1: ADC chip select, active-low.
- `x_out` output 9: screen X, 0..319.
- `y_out` output 8: screen Y, 0..239.
- `touch_valid_out` output 1: one-cycle strobe when a new `x_out`/`y_out` is presented.
- `pressed_out` output 1: level, pen considered down.

## Operation
- States:
  - IDLE → WAIT after reset.
  - WAIT: timer running. At expiry, if the synchronised pen is down, go to BURST. If the pen is up, drop `pressed_out` and reload the timer.
  - BURST: 2^AVG_LOG2 × (X frame, Y frame), back to back.
  - SCALE: 1 cycle.
  - OUT: 1 cycle, then WAIT.
- Frame:
  - 24 SCLK cycles with CS low.
  - MOSI carries the command MSB-first on SCLK cycles 0..7, changed while SCLK is low. X command is `8'hD0`, Y command is `8'h90`. MOSI is 0 after the command.
  - MISO is sampled on the rising edge of SCLK cycles 9..20 into raw[11:0], MSB first.
- Accumulation:
  - Separate X and Y sums, each 12+AVG_LOG2 bits, cleared at BURST entry.
  - avg = sum >> AVG_LOG2, giving 12 bits.
- Scaling, exact, 21-bit intermediates:
  - x = (avg_x·320)>>12, computed as ((a<<8)+(a<<6))>>12.
  - y = (avg_y·240)>>12, computed as ((a<<8)−(a<<4))>>12.
  - Maximum results are 319 and 239, so no clamping is required.
- Pen check at end of BURST:
  - Pen up: discard the result, no strobe, `pressed_out` ← 0, go to WAIT.
  - Pen down: `x_out`/`y_out` update in OUT, `touch_valid_out` = 1 for that cycle, `pressed_out` ← 1.
- `x_out`/`y_out` hold their last valid value between strobes.

## Timing
- Reset values: `spi_cs_n_out` = 1, `spi_sclk_out` = 0, `spi_mosi_out` = 0, `x_out` = 0, `y_out` = 0, `touch_valid_out` = 0, `pressed_out` = 0. Timer = SAMPLE_PERIOD.
- Reset mid-frame: all of the above take effect immediately (asynchronous). The partial sums are discarded.
- CS setup and hold:
  - CS falls one half-period before the first SCLK rise.
  - CS rises one half-period after the last SCLK fall.
  - CS stays high for at least one half-period between frames.
- Latency: `touch_valid_out` asserts exactly 2 `clk_in` cycles after the final CS rise of a burst (SCALE, then OUT).
- Sample timer:
  - Reloads at BURST entry.
  - If a burst outlasts SAMPLE_PERIOD, the next burst check happens on the first WAIT cycle.
- Pen changes during a burst are ignored until the end-of-burst check.

## Configuration
- `TOUCH_MIRROR_X_EN` defined: `x_out` = 319 − x. This is for panels mounted with the X axis reversed.
- Undefined: `x_out` = x.
- Y is unaffected in both cases.

## Structure
- `touch_pkg` holds:
  - the state enum;
  - `CMD_X` = 8'hD0 and `CMD_Y` = 8'h90;
  - `SCREEN_W` = 320 and `SCREEN_H` = 240;
  - `FRAME_SCLKS` = 24.
- Sub-module `spi_xfer24` runs one frame.
  - Interface: `start`/`busy`/`done` handshake, `cmd[7:0]` in, `data[11:0]` out.
  - `done` is a one-cycle pulse.
  - `start` is ignored while `busy`.
- The top level owns the timer, the sums, the scaler and the FSM.

## Test plan
- ADC model returns 0xFFF for X and Y, pen held down, AVG_LOG2 = 2 → 8 frames per burst, then `x_out` = 319, `y_out` = 239, one `touch_valid_out` pulse, `pressed_out` = 1.
- X raw 0x800, Y raw 0x400 → `x_out` = 160, `y_out` = 60. The strobe lands 2 cycles after the last CS rise.
- Pen held up for 3 sample periods → `spi_cs_n_out` never falls, no strobe, `pressed_out` = 0.
- Pen released during frame 5 of a burst → the burst completes, no strobe, `pressed_out` falls, outputs keep their old values.
- `rst_n_in` asserted during SCLK cycle 12 → CS = 1 and SCLK = 0 immediately, all outputs 0. The next burst produces correct values.
- `TOUCH_MIRROR_X_EN` defined with X raw 0 → `x_out` = 319. With X raw 0xFFF → `x_out` = 0.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types, constants and scaling helpers for the touch ADC reader.
// Optional build macro used by the top level: TOUCH_MIRROR_X_EN.
package touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_SCALE,
        ST_OUT
    } touch_state_t;

    typedef enum logic [2:0] {
        XF_IDLE,
        XF_SETUP,
        XF_CLOCK,
        XF_HOLD,
        XF_GUARD
    } xfer_state_t;

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;

    localparam int SCREEN_W          = 320;
    localparam int SCREEN_H          = 240;
    localparam int FRAME_SCLKS       = 24;
    localparam int CMD_BITS          = 8;
    localparam int FIRST_SAMPLE_SCLK = 9;
    localparam int LAST_SAMPLE_SCLK  = 20;

    // a*320 = (a<<8)+(a<<6); the 21-bit intermediate keeps the product exact
    function automatic logic [8:0] scale_x(input logic [11:0] a);
        logic [20:0] a21;
        logic [20:0] t;
        a21 = {9'd0, a};
        t   = (a21 << 8) + (a21 << 6);
        return 9'(t >> 12);
    endfunction

    function automatic logic [7:0] scale_y(input logic [11:0] a);
        logic [20:0] a21;
        logic [20:0] t;
        a21 = {9'd0, a};
        t   = (a21 << 8) - (a21 << 4);
        return 8'(t >> 12);
    endfunction

endpackage

// File: rtl/touch_adc_reader_spi_xfer24.sv
// spi_xfer24: one 24-SCLK SPI frame to the touch ADC (8-bit command out, 12-bit result in).
// CS leads the first SCLK rise and trails the last fall by one half-period, then idles high for one more.
module spi_xfer24
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        miso,
    output logic        busy,
    output logic        done,
    output logic [11:0] data,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    xfer_state_t state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    cyc_q, cyc_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [11:0]   data_q, data_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          done_q, done_d;

    logic       half_tick;
    logic [4:0] next_cyc;

    assign half_tick = (div_q == DIV_LAST);
    assign next_cyc  = cyc_q + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= XF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            XF_IDLE:  if (start) state_d = XF_SETUP;
            XF_SETUP: if (half_tick) state_d = XF_CLOCK;
            XF_CLOCK: if (half_tick && sclk_q && cyc_q == 5'(FRAME_SCLKS - 1)) state_d = XF_HOLD;
            XF_HOLD:  if (half_tick) state_d = XF_GUARD;
            XF_GUARD: if (half_tick) state_d = XF_IDLE;
            default:  state_d = XF_IDLE;
        endcase
    end

    always_comb begin
        div_d  = half_tick ? '0 : div_q + DW'(1);
        cyc_d  = cyc_q;
        cmd_d  = cmd_q;
        data_d = data_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_n_d = cs_n_q;
        done_d = 1'b0;
        case (state_q)
            XF_IDLE: begin
                div_d = '0;
                if (start) begin
                    cs_n_d = 1'b0;
                    cmd_d  = cmd;
                    mosi_d = cmd[7];
                    data_d = '0;
                    cyc_d  = '0;
                end
            end
            XF_SETUP: begin
                if (half_tick) sclk_d = 1'b1;
            end
            XF_CLOCK: begin
                if (half_tick) begin
                    if (sclk_q) begin
                        // Falling edge: present the next command bit while SCLK is low
                        sclk_d = 1'b0;
                        if (cyc_q < 5'(CMD_BITS - 1)) begin
                            mosi_d = cmd_q[3'd6 - cyc_q[2:0]];
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        cyc_d  = next_cyc;
                        if (next_cyc >= 5'(FIRST_SAMPLE_SCLK) && next_cyc <= 5'(LAST_SAMPLE_SCLK)) begin
                            data_d = {data_q[10:0], miso};
                        end
                    end
                end
            end
            XF_HOLD: begin
                if (half_tick) begin
                    cs_n_d = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            cyc_q  <= '0;
            cmd_q  <= '0;
            data_q <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_n_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cyc_q  <= cyc_d;
            cmd_q  <= cmd_d;
            data_q <= data_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_n_q <= cs_n_d;
            done_q <= done_d;
        end
    end

    assign busy = (state_q != XF_IDLE);
    assign done = done_q;
    assign data = data_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

endmodule

// File: rtl/touch_adc_reader.sv
// touch_adc_reader: periodic XPT2046 burst sampling, averaging and scaling to 320x240.
// Define TOUCH_MIRROR_X_EN to report x as 319 - x for panels with a reversed X axis.
module touch_adc_reader
    import touch_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 1_000_000,
    parameter int AVG_LOG2      = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       penirq_n_in,
    input  logic       spi_miso_in,
    output logic       spi_sclk_out,
    output logic       spi_mosi_out,
    output logic       spi_cs_n_out,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic       touch_valid_out,
    output logic       pressed_out
);

    localparam int FRAMES = 2 << AVG_LOG2;
    localparam int FW     = AVG_LOG2 + 2;
    localparam int SW     = 12 + AVG_LOG2;
    localparam int TW     = $clog2(SAMPLE_PERIOD + 1);

    touch_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [SW-1:0] x_sum_q, x_sum_d;
    logic [SW-1:0] y_sum_q, y_sum_d;
    logic [8:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic          valid_q, valid_d;
    logic          pressed_q, pressed_d;
    logic          pen_meta_q, pen_sync_q;

    logic        xfer_start, xfer_busy, xfer_done;
    logic [7:0]  xfer_cmd;
    logic [11:0] xfer_data;

    logic        pen_down, timer_done, burst_end;
    logic [11:0] avg_x, avg_y;
    logic [8:0]  x_scaled, x_final;
    logic [7:0]  y_scaled;

    spi_xfer24 #(.CLK_DIV(CLK_DIV)) u_xfer (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .start (xfer_start),
        .cmd   (xfer_cmd),
        .miso  (spi_miso_in),
        .busy  (xfer_busy),
        .done  (xfer_done),
        .data  (xfer_data),
        .sclk  (spi_sclk_out),
        .mosi  (spi_mosi_out),
        .cs_n  (spi_cs_n_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pen_meta_q <= 1'b1;
            pen_sync_q <= 1'b1;
        end else begin
            pen_meta_q <= penirq_n_in;
            pen_sync_q <= pen_meta_q;
        end
    end

    assign pen_down   = ~pen_sync_q;
    assign timer_done = (timer_q == '0);
    assign burst_end  = xfer_done && (frame_q == FW'(FRAMES - 1));

    assign avg_x    = 12'(x_sum_q >> AVG_LOG2);
    assign avg_y    = 12'(y_sum_q >> AVG_LOG2);
    assign x_scaled = scale_x(avg_x);
    assign y_scaled = scale_y(avg_y);

`ifdef TOUCH_MIRROR_X_EN
    assign x_final = 9'(SCREEN_W - 1) - x_scaled;
`else
    assign x_final = x_scaled;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_WAIT;
            ST_WAIT:  if (timer_done && pen_down) state_d = ST_BURST;
            ST_BURST: if (burst_end) state_d = pen_down ? ST_SCALE : ST_WAIT;
            ST_SCALE: state_d = ST_OUT;
            ST_OUT:   state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // The timer free-runs down and parks at zero, so an overlong burst is checked on the first WAIT cycle
        timer_d    = timer_done ? timer_q : timer_q - TW'(1);
        frame_d    = frame_q;
        x_sum_d    = x_sum_q;
        y_sum_d    = y_sum_q;
        x_d        = x_q;
        y_d        = y_q;
        valid_d    = 1'b0;
        pressed_d  = pressed_q;
        xfer_start = 1'b0;
        xfer_cmd   = frame_q[0] ? CMD_Y : CMD_X;
        case (state_q)
            ST_WAIT: begin
                if (timer_done) begin
                    timer_d = TW'(SAMPLE_PERIOD - 1);
                    if (pen_down) begin
                        frame_d = '0;
                        x_sum_d = '0;
                        y_sum_d = '0;
                    end else begin
                        pressed_d = 1'b0;
                    end
                end
            end
            ST_BURST: begin
                xfer_start = !xfer_busy && (frame_q < FW'(FRAMES));
                if (xfer_done) begin
                    frame_d = frame_q + FW'(1);
                    if (frame_q[0]) begin
                        y_sum_d = y_sum_q + SW'(xfer_data);
                    end else begin
                        x_sum_d = x_sum_q + SW'(xfer_data);
                    end
                    if (burst_end && !pen_down) pressed_d = 1'b0;
                end
            end
            ST_SCALE: begin
                x_d       = x_final;
                y_d       = y_scaled;
                valid_d   = 1'b1;
                pressed_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timer_q   <= TW'(SAMPLE_PERIOD);
            frame_q   <= '0;
            x_sum_q   <= '0;
            y_sum_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            x_sum_q   <= x_sum_d;
            y_sum_q   <= y_sum_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign x_out           = x_q;
    assign y_out           = y_q;
    assign touch_valid_out = valid_q;
    assign pressed_out     = pressed_q;

endmodule

// File: tb/tb_touch_adc_reader.sv
// Testbench for touch_adc_reader: behavioural XPT2046 model feeding a scoreboard of expected coordinates.
// Honours TOUCH_MIRROR_X_EN the same way as the design build.
module tb_touch_adc_reader;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 1200;
    localparam int AVG_LOG2      = 2;
    localparam int PAIRS         = 1 << AVG_LOG2;
    localparam int FRAMES        = 2 * PAIRS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pen_n;
    logic       spi_miso;
    logic       spi_sclk_out, spi_mosi_out, spi_cs_n_out;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic       touch_valid_out, pressed_out;

    int n_compared = 0;
    int n_mismatched = 0;

    int exp_x_q[$];
    int exp_y_q[$];
    int last_x = 0;
    int last_y = 0;

    logic        use_random;
    logic [11:0] fix_x, fix_y;

    int   adc_frames = 0;
    int   adc_bursts = 0;
    int   adc_err = 0;
    int   adc_rise = 0;
    int   sum_x = 0;
    int   sum_y = 0;
    logic sclk_p, cs_p;
    logic [7:0]  cmd_v;
    logic [11:0] raw_v;
    logic tail_bad;

    int   strobes = 0;
    int   cs_falls = 0;
    int   since_rise = 1000;
    logic mon_cs_p;

    touch_adc_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .AVG_LOG2      (AVG_LOG2)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .penirq_n_in     (pen_n),
        .spi_miso_in     (spi_miso),
        .spi_sclk_out    (spi_sclk_out),
        .spi_mosi_out    (spi_mosi_out),
        .spi_cs_n_out    (spi_cs_n_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .touch_valid_out (touch_valid_out),
        .pressed_out     (pressed_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pen_down, input logic rnd, input logic [11:0] fx, input logic [11:0] fy);
        pen_n      = ~pen_down;
        use_random = rnd;
        fix_x      = fx;
        fix_y      = fy;
    endtask

    task automatic waitStrobes(input string name, input int n, input int budget);
        int s0;
        int k;
        s0 = strobes;
        k  = 0;
        while (strobes < s0 + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, strobes - s0, n);
    endtask

    // Reference: the mean of the burst's raw conversions, scaled by screen size over the 12-bit full scale
    task automatic predictBurst();
        int ax, ay, ex, ey;
        ax = sum_x / PAIRS;
        ay = sum_y / PAIRS;
        ex = (ax * 320) / 4096;
        ey = (ay * 240) / 4096;
`ifdef TOUCH_MIRROR_X_EN
        ex = 319 - ex;
`endif
        if (pen_n == 1'b0) begin
            exp_x_q.push_back(ex);
            exp_y_q.push_back(ey);
        end
    endtask

    task automatic adcModel();
        sclk_p   = 1'b0;
        cs_p     = 1'b1;
        spi_miso = 1'b0;
        forever begin
            @(spi_sclk_out or spi_cs_n_out or rst_n);
            if (!rst_n) begin
                adc_frames = 0;
                adc_rise   = 0;
                sum_x      = 0;
                sum_y      = 0;
                spi_miso   = 1'b0;
            end else begin
                if (cs_p && !spi_cs_n_out) begin
                    adc_rise = 0;
                    cmd_v    = '0;
                    tail_bad = 1'b0;
                end
                if (!spi_cs_n_out && spi_sclk_out && !sclk_p) begin
                    if (adc_rise < 8) cmd_v = {cmd_v[6:0], spi_mosi_out};
                    else if (spi_mosi_out) tail_bad = 1'b1;
                    adc_rise++;
                    if (adc_rise == 8) begin
                        if (use_random) raw_v = 12'($urandom_range(0, 4095));
                        else raw_v = (cmd_v == 8'hD0) ? fix_x : fix_y;
                    end
                end
                if (!spi_cs_n_out && !spi_sclk_out && sclk_p) begin
                    spi_miso = (adc_rise >= 9 && adc_rise <= 20) ? raw_v[20 - adc_rise] : 1'b0;
                end
                if (!cs_p && spi_cs_n_out) begin
                    if (adc_rise != 24 || tail_bad ||
                        cmd_v != ((adc_frames % 2 == 0) ? 8'hD0 : 8'h90)) begin
                        adc_err++;
                        $display("[TB] ADC saw malformed frame %0d: sclks=%0d cmd=%h", adc_frames, adc_rise, cmd_v);
                    end
                    if (adc_frames % 2 == 0) sum_x += int'(raw_v);
                    else sum_y += int'(raw_v);
                    adc_frames++;
                    if (adc_frames == FRAMES) begin
                        predictBurst();
                        adc_frames = 0;
                        sum_x      = 0;
                        sum_y      = 0;
                        adc_bursts++;
                    end
                    spi_miso = 1'b0;
                end
            end
            sclk_p = spi_sclk_out;
            cs_p   = spi_cs_n_out;
        end
    endtask

    task automatic monitor();
        int ex, ey;
        mon_cs_p = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_cs_n_out && !mon_cs_p) since_rise = 0;
            else if (since_rise < 1000) since_rise++;
            if (!spi_cs_n_out && mon_cs_p) cs_falls++;
            mon_cs_p = spi_cs_n_out;
            if (touch_valid_out) begin
                strobes++;
                if (exp_x_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 1, 0);
                end else begin
                    ex = exp_x_q.pop_front();
                    ey = exp_y_q.pop_front();
                    checkOutput("x_out", int'(x_out), ex);
                    checkOutput("y_out", int'(y_out), ey);
                    checkOutput("strobe_latency", since_rise, 2);
                    checkOutput("pressed_at_strobe", int'(pressed_out), 1);
                    last_x = ex;
                    last_y = ey;
                end
            end
        end
    endtask

    initial begin
        int c0, s0, b0, k;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 12'hFFF, 12'hFFF);
        pen_n = 1'b1;
        fork
            adcModel();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("reset_cs_n", int'(spi_cs_n_out), 1);
        checkOutput("reset_sclk", int'(spi_sclk_out), 0);
        checkOutput("reset_mosi", int'(spi_mosi_out), 0);
        checkOutput("reset_x", int'(x_out), 0);
        checkOutput("reset_y", int'(y_out), 0);
        checkOutput("reset_valid", int'(touch_valid_out), 0);
        checkOutput("reset_pressed", int'(pressed_out), 0);
        rst_n = 1'b1;

        $display("[TB] full-scale burst");
        applyStimulus(1'b1, 1'b0, 12'hFFF, 12'hFFF);
        waitStrobes("fullscale_strobe", 1, 3000);
        checkOutput("fullscale_pressed", int'(pressed_out), 1);

        $display("[TB] mid-scale burst");
        applyStimulus(1'b1, 1'b0, 12'h800, 12'h400);
        waitStrobes("midscale_strobe", 1, 1500);

        $display("[TB] zero burst");
        applyStimulus(1'b1, 1'b0, 12'h000, 12'h000);
        waitStrobes("zero_strobe", 1, 1500);

        $display("[TB] random bursts");
        applyStimulus(1'b1, 1'b1, 12'h000, 12'h000);
        waitStrobes("random_strobes", 3, 4500);

        $display("[TB] pen held up");
        applyStimulus(1'b0, 1'b1, 12'h000, 12'h000);
        c0 = cs_falls;
        s0 = strobes;
        repeat (3 * SAMPLE_PERIOD) @(negedge clk);
        checkOutput("penup_cs_falls", cs_falls - c0, 0);
        checkOutput("penup_strobes", strobes - s0, 0);
        checkOutput("penup_pressed", int'(pressed_out), 0);
        checkOutput("penup_x_hold", int'(x_out), last_x);
        checkOutput("penup_y_hold", int'(y_out), last_y);

        $display("[TB] pen released during frame 5");
        applyStimulus(1'b1, 1'b1, 12'h000, 12'h000);
        waitStrobes("prerelease_strobe", 1, 2500);
        k = 0;
        while (!(adc_frames == 4 && !spi_cs_n_out) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame5_reached", int'(k < 3000), 1);
        b0 = adc_bursts;
        s0 = strobes;
        pen_n = 1'b1;
        k = 0;
        while (adc_bursts == b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("release_burst_completed", adc_bursts - b0, 1);
        repeat (10) @(negedge clk);
        checkOutput("release_pressed", int'(pressed_out), 0);
        checkOutput("release_strobes", strobes - s0, 0);
        checkOutput("release_x_hold", int'(x_out), last_x);
        checkOutput("release_y_hold", int'(y_out), last_y);

        $display("[TB] reset during SCLK cycle 12");
        applyStimulus(1'b1, 1'b1, 12'h000, 12'h000);
        k = 0;
        while (!(adc_rise == 13 && !spi_cs_n_out) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput("cycle12_reached", int'(k < 3000), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_cs_n", int'(spi_cs_n_out), 1);
        checkOutput("midreset_sclk", int'(spi_sclk_out), 0);
        checkOutput("midreset_mosi", int'(spi_mosi_out), 0);
        checkOutput("midreset_x", int'(x_out), 0);
        checkOutput("midreset_y", int'(y_out), 0);
        checkOutput("midreset_valid", int'(touch_valid_out), 0);
        checkOutput("midreset_pressed", int'(pressed_out), 0);
        last_x = 0;
        last_y = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitStrobes("postreset_strobe", 1, 3000);
        checkOutput("postreset_pressed", int'(pressed_out), 1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", exp_x_q.size(), 0);
        checkOutput("adc_frame_errors", adc_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
